// File: rtl/dsram_like_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dsram_like_bridge
// Brief    : Single-cycle data-SRAM port to SRAM-like req/addr_ok/data_ok
//            bridge with data-side stall generation. Define DSRAM_TIMEOUT_EN
//            to add the bus watchdog and the bus_err output.
// Revision : 1.0
// ============================================================================
module dsram_like_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        memwriteM,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [DATA_W-1:0] writedataM,
    input  logic              cpu_stall,
    output logic [DATA_W-1:0] readdataM,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
`ifdef DSRAM_TIMEOUT_EN
    output logic              bus_err,
`endif
    input  logic [DATA_W-1:0] data_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              w_issue;
    logic              w_capture;
    logic              w_timeout;
    logic [1:0]        w_size;

    assign w_issue   = (state_q == S_IDLE) && mem_en;
    assign w_capture = ((state_q == S_ADDR) && data_addr_ok && data_data_ok) ||
                       ((state_q == S_WAIT) && data_data_ok);

    // Bus transfer size derived from the byte-enable pattern on stores.
    always_comb begin
        w_size = data_size;
        if (|memwriteM) begin
            if ($countones(memwriteM) == 1) begin
                w_size = 2'd0;
            end else if ((memwriteM == 4'b0011) || (memwriteM == 4'b1100)) begin
                w_size = 2'd1;
            end else begin
                w_size = 2'd2;
            end
        end
    end

`ifdef DSRAM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC >= 256) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    // Counts cycles the transaction has spent in ADDR and WAIT combined.
    assign w_timeout = (((state_q == S_ADDR) && !data_addr_ok) ||
                        ((state_q == S_WAIT) && !data_data_ok)) &&
                       (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= w_timeout;
            if (w_issue) begin
                cnt_q <= '0;
            end else if ((state_q == S_ADDR) || (state_q == S_WAIT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus_err = bus_err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_en) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (data_addr_ok && data_data_ok) begin
                    state_d = S_DONE;
                end else if (data_addr_ok) begin
                    state_d = S_WAIT;
                end else if (w_timeout) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (data_data_ok || w_timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Leave only when the pipeline advances, so nothing is re-issued.
                if (!cpu_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_req = (state_q == S_ADDR);
        d_stall  = rst && mem_en && (state_q != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (w_issue) begin
                wr_q    <= |memwriteM;
                size_q  <= w_size;
                addr_q  <= aluoutM;
                wdata_q <= writedataM;
            end
            if (w_capture && !wr_q) begin
                rdata_q <= data_rdata;
            end else if (w_timeout && !wr_q) begin
                rdata_q <= DATA_W'(32'hDEAD_BEEF);
            end
        end
    end

    assign data_wr     = wr_q;
    assign data_size_o = size_q;
    assign data_addr   = addr_q;
    assign data_wdata  = wdata_q;
    assign readdataM   = rdata_q;

endmodule
`default_nettype wire

// File: doc/dsram_like_bridge.md
Name: dsram_like_bridge

Overview:
- Sits directly downstream of the core's memory stage.
- Converts the single-cycle data-SRAM port (memwriteM, aluoutM, writedataM, readdataM) into an SRAM-like request/handshake bus: req, addr_ok, data_ok.
- Generates the data-side pipeline stall, and holds returned read data until the rest of the pipeline releases its own stall.
- Each CPU access is issued exactly once, even when the pipeline stays frozen afterwards.

Parameters:
- ADDR_W, 32, width of address buses.
- DATA_W, 32, width of data buses; only 32 is supported.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with DSRAM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_en  in  1  M-stage instruction is a load or store.
- memwriteM  in  4  byte write enables; 0 means read.
- data_size  in  2  read size: 0 = byte, 1 = half, 2 = word.
- aluoutM  in  ADDR_W  access address.
- writedataM  in  DATA_W  lane-aligned store data.
- cpu_stall  in  1  stall from all other sources (ifetch, div), excluding this block.
- readdataM  out  DATA_W  load data to the core.
- d_stall  out  1  data-side stall to the hazard unit.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size_o  out  2  bus transfer size.
- data_addr  out  ADDR_W  bus address.
- data_wdata  out  DATA_W  bus write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  data phase complete.
- data_rdata  in  DATA_W  bus read data.
- bus_err  out  1  watchdog expiry; exists only with DSRAM_TIMEOUT_EN.

Behaviour:
- States: IDLE, ADDR, WAIT, DONE.
- Reset (rst=0, async):
  - state = IDLE.
  - data_req, data_wr, data_size_o, data_addr, data_wdata, readdataM and bus_err all 0.
  - d_stall = 0, because mem_en is ignored while in reset.
- IDLE:
  - mem_en=1 → latch the bus fields, then go to ADDR next cycle.
  - data_wr = |memwriteM.
  - data_addr = aluoutM.
  - data_wdata = writedataM.
  - data_size_o for writes: one-hot enables → 0; 4'b0011 or 4'b1100 → 1; any other nonzero pattern → 2.
  - data_size_o for reads: data_size.
- ADDR:
  - data_req=1; all bus fields are held stable until data_addr_ok=1.
  - addr_ok only → WAIT.
  - addr_ok and data_ok in the same cycle → DONE, and capture data_rdata.
  - data_ok without addr_ok → ignored.
- WAIT:
  - data_req=0.
  - data_ok=1 → capture data_rdata into readdataM (reads only; writes leave readdataM unchanged), then go to DONE.
- DONE:
  - Access is complete; readdataM is held.
  - cpu_stall=0 → IDLE next cycle (the pipeline advances on this edge).
  - cpu_stall=1 → remain in DONE; no re-issue.
- d_stall = mem_en & (state != DONE), combinational.
  - In IDLE, d_stall is high in the same cycle mem_en rises.
- Minimum latency: mem_en at cycle 0, req at cycle 1 with addr_ok+data_ok, DONE at cycle 2. d_stall is high for 2 cycles.
- mem_en drops in ADDR or WAIT (flush): the transaction still completes.
  - data_req is never withdrawn before addr_ok.
  - The FSM then passes through DONE to IDLE, and the read data is discarded by the core.
- data_ok arriving in IDLE or DONE (stray, e.g. after reset) → ignored.
- Only one outstanding transaction at a time.
- A new access is never issued in the DONE→IDLE cycle.

Optional Feature:
- Macro: DSRAM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering ADDR and counts cycles spent in ADDR or WAIT.
  - Reaching TIMEOUT_CYC → bus_err is pulsed for 1 cycle and the FSM is forced to DONE; readdataM = 32'hDEAD_BEEF on reads.
- Undefined: no counter and no bus_err port; the FSM waits indefinitely.

Test Plan:
- Word load, zero-wait bus:
  - Stimulus: mem_en=1, memwriteM=0, data_size=2, aluoutM=0x1000, addr_ok and data_ok in the same cycle, data_rdata=0x12345678.
  - Response: data_req=1 for exactly 1 cycle, size 2, addr 0x1000; readdataM=0x12345678; d_stall high for exactly 2 cycles.
- Byte store with 3-cycle addr_ok delay:
  - Stimulus: memwriteM=4'b0100, aluoutM=0x2002, writedataM=0x00AB0000.
  - Response: data_req held for 3 cycles with data_wr=1, data_size_o=0, addr 0x2002, wdata 0x00AB0000 stable throughout; then WAIT.
- Held pipeline:
  - Stimulus: load completes while cpu_stall=1 for 5 more cycles.
  - Response: only one data_req pulse; d_stall=0 while in DONE; readdataM held; IDLE one cycle after cpu_stall falls.
- Flush mid-transaction:
  - Stimulus: mem_en drops while in WAIT.
  - Response: the FSM waits for data_ok, passes through DONE to IDLE, and issues no extra request.
- Async reset in WAIT:
  - Stimulus: rst=0 in WAIT, then a stray data_ok after release.
  - Response: all outputs 0 immediately; the stray data_ok is ignored and readdataM stays 0.
- With DSRAM_TIMEOUT_EN and TIMEOUT_CYC=4:
  - Stimulus: never assert addr_ok.
  - Response: bus_err pulses after 4 cycles; readdataM=0xDEADBEEF; d_stall drops.
